accum_control_fsm: RTL

Multicycle control unit for the 16-bit accumulator processor. It sequences fetch, decode, execute, memory and writeback, and generates every datapath control signal. One of those signals is the 5-bit `WbSel` that drives the select input of the accumulator-writeback 16-bit 10-input mux directly downstream. Memory accesses use a ready handshake, so the block tolerates variable-latency memory.

---
 rtl/accum_control_fsm_pkg.sv | 78 +++++++
 rtl/accum_control_outputs.sv | 110 +++++++++++
 rtl/accum_control_fsm.sv | 92 +++++++++
 3 files changed

// File: rtl/accum_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_control_fsm_pkg
// Description : Shared definitions for the accumulator processor control
//               unit: opcodes, FSM state encoding, writeback-mux source
//               codes, PC source codes and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_control_fsm_pkg;

   // Opcodes, taken from Inst[15:12]. 4'hA..4'hE are undefined.
   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_LOAD  = 4'h4;
   localparam logic [3:0] OP_STORE = 4'h5;
   localparam logic [3:0] OP_LI    = 4'h6;
   localparam logic [3:0] OP_BEQ   = 4'h7;
   localparam logic [3:0] OP_JUMP  = 4'h8;
   localparam logic [3:0] OP_SLT   = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Control FSM states, binary encoded.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_WB     = 4'd6,
      S_BRANCH = 4'd7,
      S_JUMP   = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   // Writeback mux sources. Codes 3..9 are reserved for future sources.
   localparam logic [4:0] WB_ALU = 5'd0;
   localparam logic [4:0] WB_MEM = 5'd1;
   localparam logic [4:0] WB_IMM = 5'd2;

   // PC source select codes.
   localparam logic [1:0] PC_PLUS2  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   // ALU operation code used by SLT; other ALU ops use opcode[2:0].
   localparam logic [2:0] ALU_SLT = 3'd4;

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'hA) && (op <= 4'hE);
   endfunction

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_SLT);
   endfunction

   function automatic logic [2:0] alu_op_of(input logic [3:0] op);
      return (op == OP_SLT) ? ALU_SLT : op[2:0];
   endfunction

   // State following DECODE for a given opcode.
   function automatic state_t decode_next(input logic [3:0] op);
      state_t nxt;
      nxt = S_FETCH;
      if (is_alu_op(op) || (op == OP_LI)) nxt = S_EXEC;
      else if (op == OP_LOAD)             nxt = S_MEMRD;
      else if (op == OP_STORE)            nxt = S_MEMWR;
      else if (op == OP_BEQ)              nxt = S_BRANCH;
      else if (op == OP_JUMP)             nxt = S_JUMP;
      else if (op == OP_HALT)             nxt = S_HALT;
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/accum_control_outputs.sv
`default_nettype none
// ============================================================================
// Module      : accum_control_outputs
// Description : Purely combinational decode of (state, opcode, MemReady,
//               Zero) into every datapath control signal.
// Ports       : state     - current FSM state
//               opcode    - opcode latched during DECODE
//               inst_op   - live opcode field of Inst (used in DECODE)
//               MemReady  - memory completes the access this cycle
//               Zero      - accumulator-zero flag
//               PCWrite..Illegal - control outputs, see top level
// Revision    : 1.0 - initial release
// ============================================================================
module accum_control_outputs
   import accum_control_fsm_pkg::*;
#(
   parameter int OPW = 4
) (
   input  state_t           state,
   input  logic [OPW-1:0]   opcode,
   input  logic [OPW-1:0]   inst_op,
   input  logic             MemReady,
   input  logic             Zero,
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             IRWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [2:0]       AluOp,
   output logic             AccWrite,
   output logic [4:0]       WbSel,
   output logic             Halted,
   output logic             Illegal
);

   logic [3:0] w_op;
   logic [3:0] w_inst_op;

   assign w_op      = 4'(opcode);
   assign w_inst_op = 4'(inst_op);

   always_comb begin
      PCWrite  = 1'b0;
      PCSrc    = PC_PLUS2;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      AluOp    = 3'd0;
      AccWrite = 1'b0;
      WbSel    = WB_ALU;
      Halted   = 1'b0;
      Illegal  = 1'b0;

      case (state)
         S_FETCH: begin
            // Request is held for the whole access; the IR/PC loads
            // happen only in the cycle the memory completes.
            MemRead = 1'b1;
            IorD    = 1'b0;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               PCSrc   = PC_PLUS2;
            end
         end
         S_DECODE: begin
            // The opcode register is only loaded at the end of DECODE,
            // so the live instruction field is decoded here.
            Illegal = is_illegal(w_inst_op);
         end
         S_EXEC: begin
            AccWrite = 1'b1;
            if (w_op == OP_LI) begin
               WbSel = WB_IMM;
            end else begin
               WbSel = WB_ALU;
               AluOp = alu_op_of(w_op);
            end
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_WB: begin
            AccWrite = 1'b1;
            WbSel    = WB_MEM;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_BRANCH: begin
            PCSrc   = PC_BRANCH;
            PCWrite = Zero;
         end
         S_JUMP: begin
            PCSrc   = PC_JUMP;
            PCWrite = 1'b1;
         end
         S_HALT: begin
            Halted = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/accum_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : accum_control_fsm
// Description : Multicycle control unit for the 16-bit accumulator
//               processor. Holds the state and opcode registers and the
//               next-state logic; outputs are decoded combinationally by
//               accum_control_outputs.
// Ports       : CLK       - system clock, rising edge
//               Reset     - asynchronous active-high reset (state IDLE)
//               Inst      - instruction register, only [15:12] used
//               Zero      - accumulator-zero flag
//               MemReady  - memory access completes this cycle
//               PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite,
//               AluOp, AccWrite, WbSel, Halted, Illegal - control outputs
// Revision    : 1.0 - initial release
// ============================================================================
module accum_control_fsm
   import accum_control_fsm_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic [15:0]   Inst,
   input  logic          Zero,
   input  logic          MemReady,
   output logic          PCWrite,
   output logic [1:0]    PCSrc,
   output logic          IRWrite,
   output logic          IorD,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [2:0]    AluOp,
   output logic          AccWrite,
   output logic [4:0]    WbSel,
   output logic          Halted,
   output logic          Illegal
);

   state_t           r_state;
   logic [OPW-1:0]   r_opcode;
   logic [OPW-1:0]   w_inst_op;

   assign w_inst_op = Inst[15 -: OPW];

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
      end else begin
         case (r_state)
            S_IDLE:   r_state <= S_FETCH;
            S_FETCH:  if (MemReady) r_state <= S_DECODE;
            S_DECODE: begin
               r_opcode <= w_inst_op;
               r_state  <= decode_next(4'(w_inst_op));
            end
            S_EXEC:   r_state <= S_FETCH;
            S_MEMRD:  if (MemReady) r_state <= S_WB;
            S_WB:     r_state <= S_FETCH;
            S_MEMWR:  if (MemReady) r_state <= S_FETCH;
            S_BRANCH: r_state <= S_FETCH;
            S_JUMP:   r_state <= S_FETCH;
            S_HALT:   r_state <= S_HALT;   // only Reset leaves HALT
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   accum_control_outputs #(
      .OPW (OPW)
   ) u_outputs (
      .state    (r_state),
      .opcode   (r_opcode),
      .inst_op  (w_inst_op),
      .MemReady (MemReady),
      .Zero     (Zero),
      .PCWrite  (PCWrite),
      .PCSrc    (PCSrc),
      .IRWrite  (IRWrite),
      .IorD     (IorD),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .AluOp    (AluOp),
      .AccWrite (AccWrite),
      .WbSel    (WbSel),
      .Halted   (Halted),
      .Illegal  (Illegal)
   );

endmodule
`default_nettype wire
